// File: rtl/gate_classifier.sv
// Learns the 4-entry truth table of a two-input gate from (a, b, out) samples.
// It flags inconsistent responses and classifies the gate once every entry is confirmed.
module gate_classifier #(
    parameter int MIN_HITS = 2,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid,
    input  logic       a,
    input  logic       b,
    input  logic       out,
    input  logic       clear,
    output logic [3:0] truth,
    output logic [3:0] known,
    output logic       done,
    output logic       fault,
    output logic       mismatch,
    output logic [1:0] mismatch_id,
    output logic [2:0] gate_code
);

    typedef enum logic [1:0] {
        ST_LEARN = 2'd0,
        ST_DONE  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MIN_HITS_C = CNT_W'(MIN_HITS);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       truth_q, truth_d;
    logic [3:0]       seen_q, seen_d;
    logic [3:0]       known_q, known_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic             mismatch_q, mismatch_d;
    logic [1:0]       mismatch_id_q, mismatch_id_d;
    logic [2:0]       gate_code_q, gate_code_d;

    logic [1:0] idx;
    logic       learning;
    logic       conflict;

    assign idx      = {a, b};
    // The table and counters only move in LEARN/DONE; clear always discards the sample.
    assign learning = sample_valid && !clear && (state_q != ST_FAULT);
    assign conflict = sample_valid && !clear && seen_q[idx] && (out != truth_q[idx]);

    function automatic logic [2:0] decode_gate(input logic [3:0] t);
        case (t)
            4'b1000: decode_gate = 3'd1;
            4'b1110: decode_gate = 3'd2;
            4'b0110: decode_gate = 3'd3;
            4'b0111: decode_gate = 3'd4;
            4'b0001: decode_gate = 3'd5;
            4'b1001: decode_gate = 3'd6;
            default: decode_gate = 3'd7;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_entry
            logic sel;
            logic first;
            logic agree;

            assign sel   = learning && (idx == 2'(gi));
            assign first = sel && !seen_q[gi];
            assign agree = sel && seen_q[gi] && (out == truth_q[gi]);

            assign truth_d[gi] = clear ? 1'b0 : (first ? out : truth_q[gi]);
            assign seen_d[gi]  = clear ? 1'b0 : (seen_q[gi] | first);
            // The counter saturates at MIN_HITS, so known stays set for as long as the entry does.
            assign cnt_d[gi]   = clear ? '0 :
                                 first ? ONE_C :
                                 (agree && (cnt_q[gi] < MIN_HITS_C)) ? cnt_q[gi] + ONE_C :
                                 cnt_q[gi];
            assign known_d[gi] = (cnt_d[gi] >= MIN_HITS_C);
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        fault_d       = fault_q;
        mismatch_d    = 1'b0;
        mismatch_id_d = mismatch_id_q;
        done_d        = 1'b0;
        gate_code_d   = 3'd0;

        if (clear) begin
            state_d       = ST_LEARN;
            fault_d       = 1'b0;
            mismatch_id_d = 2'd0;
        end else if (conflict) begin
            state_d       = ST_FAULT;
            fault_d       = 1'b1;
            mismatch_d    = 1'b1;
            mismatch_id_d = idx;
        end else if (state_q == ST_LEARN && known_d == 4'hF) begin
            state_d = ST_DONE;
        end

        case (state_d)
            ST_DONE: begin
                done_d      = 1'b1;
                gate_code_d = decode_gate(truth_d);
            end
            ST_FAULT: gate_code_d = 3'd7;
            default:  gate_code_d = 3'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_LEARN;
            truth_q       <= '0;
            seen_q        <= '0;
            known_q       <= '0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            mismatch_q    <= 1'b0;
            mismatch_id_q <= 2'd0;
            gate_code_q   <= 3'd0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            truth_q       <= truth_d;
            seen_q        <= seen_d;
            known_q       <= known_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
            mismatch_q    <= mismatch_d;
            mismatch_id_q <= mismatch_id_d;
            gate_code_q   <= gate_code_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign truth       = truth_q;
    assign known       = known_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign mismatch    = mismatch_q;
    assign mismatch_id = mismatch_id_q;
    assign gate_code   = gate_code_q;

endmodule

// File: doc/gate_classifier.md
Name: gate_classifier

Overview:
- Receive-side companion to the two-input gate test benches.
- Observes a stream of (a, b, out) samples taken from a two-input gate under test, and learns the gate's 4-entry truth table.
- Flags any inconsistent response and, once every input combination has been confirmed, classifies the gate as AND/OR/XOR/NAND/NOR/XNOR/other.
- Sits downstream of a stimulus driver or a BIST sweeper. Its verdict replaces per-case $display checking.

Parameters:
- MIN_HITS, 2: number of agreeing samples required per input combination before that entry counts as confirmed (legal range 1..15).
- CNT_W, 4: width of each per-entry hit counter. Must satisfy 2^CNT_W - 1 >= MIN_HITS.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sample_valid  input  1  a, b and out are a valid sample this cycle.
- a  input  1  gate input a of the sample.
- b  input  1  gate input b of the sample.
- out  input  1  observed gate output for the sample.
- clear  input  1  synchronous restart of learning; one-cycle pulse.
- truth  output  4  learned table; truth[{a,b}] = observed out.
- known  output  4  known[i]=1 once entry i has reached MIN_HITS agreeing samples.
- done  output  1  all four entries known and no conflict; level.
- fault  output  1  sticky conflict flag; level.
- mismatch  output  1  one-cycle pulse on the cycle after a conflicting sample.
- mismatch_id  output  2  {a,b} index of the most recent conflict; holds its value.
- gate_code  output  3  0 = not done, 1 = AND, 2 = OR, 3 = XOR, 4 = NAND, 5 = NOR, 6 = XNOR, 7 = other or fault.

Behaviour:
- Reset (rst_n low, asynchronous):
  - truth = 0, known = 0, all hit counters = 0, seen flags = 0.
  - done = 0, fault = 0, mismatch = 0, mismatch_id = 0, gate_code = 0.
  - State = LEARN.
- State machine, three states:
  - LEARN -> DONE when all four known bits are 1 after the current update.
  - LEARN -> FAULT on a conflict.
  - DONE -> FAULT on a conflict.
  - DONE and FAULT hold until clear is asserted or reset.
  - clear in any state -> LEARN with the reset values above.
- Sample handling: samples are processed when sample_valid = 1 in LEARN or DONE. Let i = {a,b}.
  - First sample for entry i (seen[i] = 0): truth[i] <= out, seen[i] <= 1, counter[i] <= 1.
  - Agreeing sample (out == truth[i]): counter[i] increments and saturates at MIN_HITS.
  - known[i] is set when counter[i] reaches MIN_HITS.
  - Conflicting sample (out != truth[i]):
    - truth[i] is not changed.
    - fault <= 1, mismatch pulses for exactly one cycle, mismatch_id <= i.
    - State goes to FAULT.
- Samples in FAULT: ignored for table update and counting. Another conflicting sample still pulses mismatch and updates mismatch_id; it has no other effect.
- All outputs are registered. Latency from a sample cycle to the visible known/done/fault/mismatch/gate_code change is 1 clock.
- gate_code:
  - 0 in LEARN.
  - 7 in FAULT.
  - In DONE, decoded from truth[3:0]: 1000 -> 1, 1110 -> 2, 0110 -> 3, 0111 -> 4, 0001 -> 5, 1001 -> 6, any other pattern -> 7.
  - Registered together with done, so done and a nonzero gate_code rise in the same cycle.
- Simultaneous clear and sample_valid: clear wins and the sample is discarded.
- Samples arriving after DONE continue to be checked. A conflict moves the block to FAULT and drops done the next cycle.
- Reset asserted mid-learning takes effect immediately (asynchronous) and discards all partial state.
- MIN_HITS = 1: an entry is known on its first sample.

Test Plan:
- OR sweep: (0,0,0), (0,1,1), (1,0,1), (1,1,1), each presented twice with MIN_HITS = 2 -> after the 8th sample, next cycle: truth = 1110, known = 1111, done = 1, gate_code = 2, fault = 0.
- Partial table: only combinations 00, 01 and 10 presented, each 3 times -> known = 0111, done = 0, gate_code = 0.
- Conflict: (1,1,1), then (1,1,0) -> one-cycle mismatch pulse, mismatch_id = 3, fault = 1, gate_code = 7, truth[3] still 1. Further samples leave the table unchanged.
- Post-done conflict: learn XOR fully (gate_code = 3), then feed (0,0,1) -> done falls to 0, fault = 1, gate_code = 7 one cycle later.
- clear and sample_valid asserted together after a fault -> all outputs return to reset values and the sample is not counted. A subsequent AND sweep yields gate_code = 1.
- rst_n pulsed low asynchronously between clock edges mid-sweep -> outputs zero immediately. Relearning NAND afterwards yields truth = 0111, gate_code = 4.
